ptp_framer: RTL
===============

PTP_FRAMER -- requirements
Module: ptp_framer

Interface
REQ-001 Parameter PREFIX, 32'h00000000, stream prefix word sent as word 0 of every frame.
REQ-002 Parameter DST_MAC, 48'h011B19000000, Ethernet destination address.
REQ-003 Parameter SRC_MAC, 48'h000A35000001, Ethernet source address.
REQ-004 Parameter SRC_IP, 32'hC0A80102, IPv4 source address; DST_IP, 32'hE0000181, IPv4 destination; TTL, 8'h40, IPv4 time-to-live.
REQ-005 Parameter CLOCK_ID, 64'h000A35FFFE000001, PTP clockIdentity; DOMAIN, 8'h00, PTP domainNumber.
REQ-006 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  1  request strobe; req_ready  out  1  request accepted when both high.
REQ-008 req_msgid  in  4  PTP messageType; req_seqid  in  16  sequenceId; req_sec  in  48  origin seconds; req_ns  in  32  origin nanoseconds.
REQ-009 req_err  out  1  one-cycle pulse: request dropped.
REQ-010 ptp_data  out  32  frame word, byte 0 in [31:24]; ptp_valid  out  1; ptp_sop  out  1; ptp_eop  out  1; ptp_mod  out  2  empty bytes in eop word.
REQ-011 ptp_ready  in  1  downstream accepts word when ptp_valid and ptp_ready both high.
REQ-012 tx_done  out  1  one-cycle pulse on eop-word acceptance.

Function
REQ-013 States IDLE, SUM, FOLD, SEND; req_ready SHALL be high only in IDLE.
REQ-014 On acceptance, msgid/seqid/sec/ns SHALL be captured; request inputs SHALL be ignored outside IDLE.
REQ-015 req_msgid not 0 (Sync) and not 2: IDLE->IDLE, no frame, req_err=1 the next cycle.
REQ-016 Valid msgid: IDLE->SUM->FOLD->SEND; first word (sop) SHALL be valid 3 cycles after the acceptance edge.
REQ-017 Frame: 23 words, 90 bytes: PREFIX(4), Ethernet(14), IPv4(20), UDP(8), PTP(44); word 22 carries bytes 88-89 in [31:16] with [15:0]=0 and ptp_mod=2; all other words ptp_mod=0.
REQ-018 Ethernet: DST_MAC, SRC_MAC, ethertype 0x0800 in word 4 [31:16].
REQ-019 IPv4: 0x4500, total length 0x0048, ID=ip_id, 0x4000, TTL, protocol 0x11 (word 6 [7:0]), checksum, SRC_IP, DST_IP.
REQ-020 Checksum: SUM forms a 32-bit sum of the ten header halfwords with checksum=0; FOLD adds carries twice into 16 bits and inverts.
REQ-021 UDP: source and destination port 0x013F (destination port in word 10 [31:16]), length 0x0034, checksum 0x0000.
REQ-022 PTP bytes 0-1: {4'h0,msgid},0x02; 2-3: 0x002C; 4: DOMAIN; 5: 0; 6-7: flags 0x0200 for Sync, else 0x0000; 8-19: 0.
REQ-023 PTP bytes 20-29: CLOCK_ID, port 0x0001; 30-31: seqid (word 19 [31:16]); 32: control 0x00 for Sync, else 0x05; 33: logInterval 0x00 for Sync, else 0x7F; 34-43: sec, ns.
REQ-024 The msgid nibble SHALL sit in word 11 [11:8].
REQ-025 While ptp_valid=1 and ptp_ready=0: data, sop, eop and mod SHALL hold stable; word index SHALL not advance.
REQ-026 ptp_valid SHALL be continuous in SEND (no self-inserted gaps); ptp_sop only on word 0; ptp_eop only on word 22.
REQ-027 On eop acceptance: tx_done=1, ip_id increments (16-bit, FFFF wraps to 0000), SEND->IDLE; req_ready high next cycle.
REQ-028 req_valid held high across IDLE return SHALL be accepted back-to-back; no extra idle cycle is required.

Reset
REQ-029 rst SHALL force IDLE, ip_id=0, req_ready=1 and clear req_err, ptp_valid, ptp_sop, ptp_eop, tx_done, ptp_mod and ptp_data to 0 immediately.
REQ-030 rst mid-frame SHALL truncate the frame with no eop; the next frame SHALL start at word 0 with ip_id=0.

Verification
REQ-031 Default params, req msgid=0 seqid=0x1234, ptp_ready=1 -> 23 words; word 4=0x0800xxxx; IP checksum 0x9779; word 19 [31:16]=0x1234; mod=2 on eop.
REQ-032 Second request msgid=2 -> ID=0x0001, checksum 0x9778, flags 0x0000, control 0x05, logInterval 0x7F.
REQ-033 req msgid=1 -> no ptp_valid, req_err pulse, req_ready stays 1.
REQ-034 ptp_ready low for 5 cycles at word 7 -> word 7 held unchanged, frame completes with 23 accepted words.
REQ-035 rst asserted at word 12 -> outputs cleared at once; next frame starts at word 0 with ID=0x0000.
REQ-036 Loopback into the receive parser -> found=1 with matching seqid and msgid[1:0] for msgid 0 and 2.

Source files
------------

// File: rtl/ptp_framer.sv
// ptp_framer
// Builds a fixed-layout PTP-over-UDP/IPv4/Ethernet frame as a stream of
// 32-bit words (byte 0 of each word in [31:24]). Only Sync (msgid 0) and
// Delay_Req (msgid 2) are framed. Any other msgid is dropped and flagged.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake; ready only while idle
//   req_msgid/seqid    PTP messageType and sequenceId
//   req_sec/ns         origin timestamp
//   req_err            one-cycle pulse when a request is dropped
//   ptp_data/valid     output word stream with backpressure from ptp_ready
//   ptp_sop/eop/mod    frame delimiters; mod = empty bytes in the eop word
//   tx_done            one-cycle pulse after the eop word is accepted
module ptp_framer #(
    parameter logic [31:0] PREFIX   = 32'h00000000,
    parameter logic [47:0] DST_MAC  = 48'h011B19000000,
    parameter logic [47:0] SRC_MAC  = 48'h000A35000001,
    parameter logic [31:0] SRC_IP   = 32'hC0A80102,
    parameter logic [31:0] DST_IP   = 32'hE0000181,
    parameter logic [7:0]  TTL      = 8'h40,
    parameter logic [63:0] CLOCK_ID = 64'h000A35FFFE000001,
    parameter logic [7:0]  DOMAIN   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_msgid,
    input  logic [15:0] req_seqid,
    input  logic [47:0] req_sec,
    input  logic [31:0] req_ns,
    output logic        req_err,
    output logic [31:0] ptp_data,
    output logic        ptp_valid,
    output logic        ptp_sop,
    output logic        ptp_eop,
    output logic [1:0]  ptp_mod,
    input  logic        ptp_ready,
    output logic        tx_done
);

    typedef enum logic [1:0] {IDLE, SUM, FOLD, SEND} state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        load_word;
    logic        msg_ok;
    logic        eop_accept;
    logic        is_sync;

    logic [3:0]  msgid_q;
    logic [15:0] seqid_q;
    logic [47:0] sec_q;
    logic [31:0] ns_q;
    logic [15:0] ip_id;
    logic [31:0] sum_q;
    logic [15:0] csum_q;
    logic [4:0]  idx;

    logic [31:0] hdr_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [31:0] word_data;
    logic [1:0]  word_mod;

    assign msg_ok     = (req_msgid == 4'd0) || (req_msgid == 4'd2);
    assign eop_accept = ptp_valid && ptp_ready && ptp_eop;
    assign is_sync    = (msgid_q == 4'd0);

    // The ten IPv4 header halfwords with the checksum field taken as zero.
    assign hdr_sum = 32'h00004500 + 32'h00000048 + {16'h0000, ip_id}
                   + 32'h00004000 + {16'h0000, TTL, 8'h11}
                   + {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]}
                   + {16'h0000, DST_IP[31:16]} + {16'h0000, DST_IP[15:0]};

    // Two end-around carry folds are always enough for ten halfwords; the
    // second fold cannot carry out again.
    assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
    assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new word is loaded whenever the output register is empty or its
    // current (non-eop) word is being taken, which keeps valid gap-free.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        load_word  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (msg_ok) begin
                        state_next = SUM;
                    end
                end
            end
            SUM:  state_next = FOLD;
            FOLD: state_next = SEND;
            SEND: begin
                load_word = !ptp_valid || (ptp_ready && !ptp_eop);
                if (eop_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word contents by index; offsets follow the 90-byte frame layout
    // starting with the 4-byte stream prefix.
    always_comb begin
        word_data = 32'h00000000;
        word_mod  = 2'd0;
        case (idx)
            5'd0:  word_data = PREFIX;
            5'd1:  word_data = DST_MAC[47:16];
            5'd2:  word_data = {DST_MAC[15:0], SRC_MAC[47:32]};
            5'd3:  word_data = SRC_MAC[31:0];
            5'd4:  word_data = {16'h0800, 16'h4500};
            5'd5:  word_data = {16'h0048, ip_id};
            5'd6:  word_data = {16'h4000, TTL, 8'h11};
            5'd7:  word_data = {csum_q, SRC_IP[31:16]};
            5'd8:  word_data = {SRC_IP[15:0], DST_IP[31:16]};
            5'd9:  word_data = {DST_IP[15:0], 16'h013F};
            5'd10: word_data = {16'h013F, 16'h0034};
            5'd11: word_data = {16'h0000, 4'h0, msgid_q, 8'h02};
            5'd12: word_data = {16'h002C, DOMAIN, 8'h00};
            5'd13: word_data = {(is_sync ? 16'h0200 : 16'h0000), 16'h0000};
            5'd16: word_data = {16'h0000, CLOCK_ID[63:48]};
            5'd17: word_data = CLOCK_ID[47:16];
            5'd18: word_data = {CLOCK_ID[15:0], 16'h0001};
            5'd19: word_data = {seqid_q, (is_sync ? 8'h00 : 8'h05),
                                (is_sync ? 8'h00 : 8'h7F)};
            5'd20: word_data = sec_q[47:16];
            5'd21: word_data = {sec_q[15:0], ns_q[31:16]};
            5'd22: begin
                word_data = {ns_q[15:0], 16'h0000};
                word_mod  = 2'd2;
            end
            default: word_data = 32'h00000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_err   <= 1'b0;
            tx_done   <= 1'b0;
            msgid_q   <= 4'd0;
            seqid_q   <= 16'h0000;
            sec_q     <= 48'h0;
            ns_q      <= 32'h0;
            ip_id     <= 16'h0000;
            sum_q     <= 32'h0;
            csum_q    <= 16'h0000;
            idx       <= 5'd0;
            ptp_data  <= 32'h0;
            ptp_valid <= 1'b0;
            ptp_sop   <= 1'b0;
            ptp_eop   <= 1'b0;
            ptp_mod   <= 2'd0;
        end else begin
            req_err <= accept && !msg_ok;
            tx_done <= eop_accept;
            if (accept) begin
                msgid_q <= req_msgid;
                seqid_q <= req_seqid;
                sec_q   <= req_sec;
                ns_q    <= req_ns;
            end
            if (state == SUM) begin
                sum_q <= hdr_sum;
            end
            if (state == FOLD) begin
                csum_q <= ~fold2;
                idx    <= 5'd0;
            end
            if (load_word) begin
                ptp_data  <= word_data;
                ptp_valid <= 1'b1;
                ptp_sop   <= (idx == 5'd0);
                ptp_eop   <= (idx == 5'd22);
                ptp_mod   <= word_mod;
                idx       <= idx + 5'd1;
            end else if (eop_accept) begin
                ptp_data  <= 32'h0;
                ptp_valid <= 1'b0;
                ptp_sop   <= 1'b0;
                ptp_eop   <= 1'b0;
                ptp_mod   <= 2'd0;
                ip_id     <= ip_id + 16'h0001;
            end
        end
    end

endmodule
